// File: rtl/crc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : crc_stream
//  Purpose  : Streaming CRC generator/checker for multi-beat frames with
//             valid/ready handshakes. Generate mode appends the frame CRC on
//             the last beat; check mode compares it with a received CRC.
//  Revision : 1.0  initial release
// ============================================================================
module crc_stream #(
  parameter int               DATA_W = 32,
  parameter int               CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = 8'h31,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter logic [CRC_W-1:0] XOROUT = '0,
  parameter int               CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [CRC_W-1:0]          in_crc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W+CRC_W-1:0]   out_data,
  output logic                      out_last,
  output logic                      out_err,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             mode_q;
  logic             mode_nx;
  logic [CRC_W-1:0] crc_reg;

  logic             accept;
  logic             eff_mode;
  logic [CRC_W-1:0] fin;
  logic [CRC_W-1:0] fin_x;
  logic [CRC_W-1:0] crc_field;
  logic             mismatch;

  // Non-reflected, MSB-first CRC over a whole beat: one LFSR step per data bit.
  function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] crc_in,
                                                 input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // The single output register frees up whenever it is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Mode comes live from the port on a frame's first beat, from the latch after.
  assign eff_mode = (state == IDLE) ? mode : mode_q;

  assign fin       = crc_update(crc_reg, in_data);
  assign fin_x     = fin ^ XOROUT;
  assign crc_field = in_last ? fin_x : '0;
  assign mismatch  = eff_mode && in_last && (fin_x != in_crc);

  // Frame-tracking FSM: next state and latched mode.
  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    if (accept) begin
      case (state)
        IDLE: begin
          mode_nx = mode;
          if (!in_last) begin
            state_nx = FRAME;
          end
        end
        FRAME: begin
          if (in_last) begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, latched mode and running CRC; the CRC restarts from INIT after a last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      crc_reg <= INIT;
    end else begin
      state  <= state_nx;
      mode_q <= mode_nx;
      if (accept) begin
        crc_reg <= in_last ? INIT : fin;
      end
    end
  end

  // Output register: load on acceptance, clear valid once drained, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= {in_data, crc_field};
      out_last  <= in_last;
      out_err   <= mismatch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating frame and error statistics, bumped when a last beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (accept && in_last) begin
      if (frame_cnt != CNT_MAX) begin
        frame_cnt <= frame_cnt + CNT_ONE;
      end
      if (mismatch && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crc_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_stream
//  Purpose  : Self-checking bench for crc_stream with a scoreboard of expected
//             output beats built from a polynomial long-division reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_crc_stream;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 16;

  typedef struct packed {
    logic [DW+CW-1:0] data;
    logic             last;
    logic             err;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [CW-1:0] in_crc;
  logic          out_valid;
  logic          out_ready;
  logic [DW+CW-1:0] out_data;
  logic          out_last;
  logic          out_err;
  logic [NW-1:0] frame_cnt;
  logic [NW-1:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  beat_t sb[$];
  bit    model_bits[$];
  logic  model_idle = 1'b1;
  logic  model_mode = 1'b0;
  logic [NW-1:0] exp_frames = '0;
  logic [NW-1:0] exp_errs   = '0;

  logic [DW+CW-1:0] last_data;
  logic             last_err;

  logic ready_mode = 1'b0;
  logic ready_val  = 1'b1;

  crc_stream #(
    .DATA_W(DW), .CRC_W(CW), .POLY(8'h31), .INIT(8'h00), .XOROUT(8'h00), .CNT_W(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_crc(in_crc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Downstream ready: fixed value or random, applied just after each edge.
  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? ($urandom_range(0, 1) == 1) : ready_val;
  end

  // Reference CRC: remainder of {message, CW zeros} modulo {1, POLY}.
  function automatic logic [CW-1:0] ref_crc();
    logic [CW:0] rem;
    rem = '0;
    for (int i = 0; i < model_bits.size() + CW; i++) begin
      rem = {rem[CW-1:0], (i < model_bits.size()) ? model_bits[i] : 1'b0};
      if (rem[CW]) rem = rem ^ 9'h131;
    end
    return rem[CW-1:0];
  endfunction

  // Scoreboard push for an accepted beat.
  task automatic model_accept(input logic [DW-1:0] d, input logic l,
                              input logic [CW-1:0] c, input logic m);
    beat_t        b;
    logic [CW-1:0] r;
    if (model_idle) model_mode = m;
    for (int i = DW - 1; i >= 0; i--) model_bits.push_back(d[i]);
    b.last = l;
    b.err  = 1'b0;
    if (l) begin
      r      = ref_crc();
      b.data = {d, r};
      b.err  = model_mode && (r != c);
      if (exp_frames != '1) exp_frames++;
      if (b.err && exp_errs != '1) exp_errs++;
      model_bits.delete();
      model_idle = 1'b1;
    end else begin
      b.data     = {d, 8'h00};
      model_idle = 1'b0;
    end
    sb.push_back(b);
  endtask

  // Output monitor: each transferred beat is compared with the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got data=%h last=%b with nothing expected",
                 out_data, out_last);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_last !== e.last || out_err !== e.err)
          $display("FAIL sb_beat: got data=%h last=%b err=%b, expected data=%h last=%b err=%b",
                   out_data, out_last, out_err, e.data, e.last, e.err);
        else
          n_pass++;
      end
      last_data = out_data;
      last_err  = out_err;
    end
  end

  // Drive one beat at posedge+1 and hold it until accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic l,
                           input logic [CW-1:0] c, input logic m);
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_crc   = c;
    mode     = m;
    budget   = 0;
    @(negedge clk);
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, budget);
    end else begin
      model_accept(d, l, c, m);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expected beat has left the DUT.
  task automatic drain();
    int budget;
    ready_mode = 1'b0;
    ready_val  = 1'b1;
    budget     = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0 || out_valid) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    n_checks++;
    if (frame_cnt !== exp_frames || err_cnt !== exp_errs)
      $display("FAIL %s_counters: got frames=%0d errs=%0d, expected frames=%0d errs=%0d",
               tag, frame_cnt, err_cnt, exp_frames, exp_errs);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_crc = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_data, out_last, out_err, frame_cnt, err_cnt} !== '0)
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b err=%b fc=%0d ec=%0d, expected all 0",
               out_valid, out_data, out_last, out_err, frame_cnt, err_cnt);
    else
      n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_ready: got in_ready=%b, expected 1", in_ready);
    else
      n_pass++;
  endtask

  task automatic test_generate();
    send_beat(32'h0000_0001, 1'b1, 8'h00, 1'b0);
    drain();
    n_checks++;
    if (last_data !== 40'h00_0000_0131 || last_err !== 1'b0 || frame_cnt !== 16'd1)
      $display("FAIL gen_one: got data=%h err=%b fc=%0d, expected 0000000131 0 1",
               last_data, last_err, frame_cnt);
    else
      n_pass++;
    send_beat(32'h0000_0002, 1'b1, 8'h00, 1'b0);
    drain();
    n_checks++;
    if (last_data[CW-1:0] !== 8'h62) $display("FAIL gen_two: got crc=%h, expected 62", last_data[CW-1:0]);
    else n_pass++;
    send_beat(32'h0000_0000, 1'b1, 8'h00, 1'b0);
    drain();
    n_checks++;
    if (last_data[CW-1:0] !== 8'h00) $display("FAIL gen_zero: got crc=%h, expected 00", last_data[CW-1:0]);
    else n_pass++;
    check_counters("gen");
  endtask

  task automatic test_back_to_back();
    send_beat(32'h0000_0000, 1'b0, 8'h00, 1'b0);
    send_beat(32'h0000_0001, 1'b1, 8'h00, 1'b0);
    send_beat(32'h0000_0002, 1'b1, 8'h00, 1'b0);
    drain();
    n_checks++;
    if (last_data[CW-1:0] !== 8'h62)
      $display("FAIL b2b_restart: got crc=%h, expected 62", last_data[CW-1:0]);
    else
      n_pass++;
    check_counters("b2b");
  endtask

  task automatic test_check();
    send_beat(32'h0000_0001, 1'b1, 8'h31, 1'b1);
    drain();
    n_checks++;
    if (last_err !== 1'b0 || err_cnt !== 16'd0 || last_data[CW-1:0] !== 8'h31)
      $display("FAIL chk_good: got err=%b ec=%0d crc=%h, expected 0 0 31", last_err, err_cnt, last_data[CW-1:0]);
    else
      n_pass++;
    send_beat(32'h0000_0001, 1'b1, 8'h30, 1'b1);
    drain();
    n_checks++;
    if (last_err !== 1'b1 || err_cnt !== 16'd1)
      $display("FAIL chk_bad: got err=%b ec=%0d, expected 1 1", last_err, err_cnt);
    else
      n_pass++;
    check_counters("chk");
  endtask

  task automatic test_backpressure();
    ready_val = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        send_beat(32'hA5A5_0001, 1'b0, 8'h00, 1'b0);
        send_beat(32'h1234_5678, 1'b0, 8'h00, 1'b0);
        send_beat(32'hCAFE_F00D, 1'b1, 8'h00, 1'b0);
      end
      begin
        logic [DW+CW-1:0] held;
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 10) begin @(negedge clk); k++; end
        held = out_data;
        for (int c = 0; c < 5; c++) begin
          n_checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
            $display("FAIL bp_hold: got ready=%b valid=%b data=%h, expected 0 1 %h",
                     in_ready, out_valid, out_data, held);
          else
            n_pass++;
          @(negedge clk);
        end
        ready_val = 1'b1;
      end
    join
    drain();
    check_counters("bp");
  endtask

  task automatic test_random();
    ready_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_beat($urandom, (b == nb - 1), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  $urandom_range(0, 1) == 1);
      end
    end
    drain();
    check_counters("rand");
  endtask

  task automatic test_reset_midframe();
    ready_val = 1'b0;
    @(posedge clk);
    #1;
    send_beat(32'hDEAD_BEEF, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    model_bits.delete();
    model_idle = 1'b1;
    exp_frames = '0;
    exp_errs   = '0;
    n_checks++;
    if ({out_valid, out_data, out_last, out_err, frame_cnt, err_cnt} !== '0)
      $display("FAIL midrst_zero: got valid=%b data=%h fc=%0d ec=%0d, expected all 0",
               out_valid, out_data, frame_cnt, err_cnt);
    else
      n_pass++;
    @(negedge clk);
    rst_n     = 1'b1;
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    send_beat(32'h0000_0001, 1'b1, 8'h00, 1'b0);
    drain();
    n_checks++;
    if (last_data !== 40'h00_0000_0131 || frame_cnt !== 16'd1)
      $display("FAIL midrst_fresh: got data=%h fc=%0d, expected 0000000131 1", last_data, frame_cnt);
    else
      n_pass++;
  endtask

  task automatic test_saturation();
    logic [NW-1:0] errs_before;
    errs_before = err_cnt;
    for (int i = 0; i < (1 << NW) + 2; i++) begin
      send_beat($urandom, 1'b1, 8'h00, 1'b0);
    end
    drain();
    n_checks++;
    if (frame_cnt !== 16'hFFFF || err_cnt !== errs_before)
      $display("FAIL sat_frames: got fc=%h ec=%0d, expected ffff %0d", frame_cnt, err_cnt, errs_before);
    else
      n_pass++;
    check_counters("sat");
  endtask

  initial begin
    out_ready = 1'b1;
    test_reset();
    test_generate();
    test_back_to_back();
    test_check();
    test_backpressure();
    test_random();
    test_reset_midframe();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
